// File: rtl/instr_fetch.sv
// Fetch sequencer: steers the PC, reads instructions over req/ack and hands them to the decoder.
// Optional fetch timeout/retry is enabled with the FETCH_TIMEOUT_EN macro.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned PC_LAT  = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  execadd,
  output logic               loadPC,
  output logic               incPC,
  output logic [ADDR_W-1:0]  address,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               fetch_err
);

  localparam int unsigned LAT_W = (PC_LAT > 1) ? $clog2(PC_LAT) : 1;

  if (PC_LAT < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("instr_fetch: PC_LAT and TIMEOUT must be at least 1");
  end

  // {loadPC,incPC} encodings
  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_INC   = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_HOLD  = 2'b11;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_SETTLE,
    S_FETCH,
    S_HOLD,
    S_LOAD,
    S_INC
  } state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [1:0]         pc_cmd_q, pc_cmd_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               fetch_err_q, fetch_err_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      lat_cnt_q   <= '0;
      pc_cmd_q    <= CMD_CLEAR;
      address_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      pc_cmd_q    <= pc_cmd_d;
      address_q   <= address_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; registered outputs reflect the state being entered
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    pc_cmd_d    = CMD_HOLD;
    address_d   = address_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    fetch_err_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    unique case (state_q)
      S_CLEAR: begin
        state_d   = S_SETTLE;
        lat_cnt_d = '0;
      end
      S_SETTLE: begin
        if (lat_cnt_q == LAT_W'(PC_LAT - 1)) begin
          mem_addr_d = execadd;
          mem_req_d  = 1'b1;
          state_d    = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_FETCH: begin
        // An ack only counts while the request is actually up
        if (mem_req_q && mem_ack) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (!mem_req_q) begin
          mem_req_d = 1'b1;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          tmo_cnt_d   = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          if (branch_taken) begin
            address_d = branch_target;
            pc_cmd_d  = CMD_LOAD;
            state_d   = S_LOAD;
          end else begin
            pc_cmd_d = CMD_INC;
            state_d  = S_INC;
          end
        end
      end
      S_LOAD, S_INC: begin
        state_d   = S_SETTLE;
        lat_cnt_d = '0;
      end
      default: begin
        state_d  = S_CLEAR;
        pc_cmd_d = CMD_CLEAR;
      end
    endcase
  end

  assign loadPC    = pc_cmd_q[1];
  assign incPC     = pc_cmd_q[0];
  assign address   = address_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a two-stage PC model and a req/ack instruction memory.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] execadd;
  logic       loadPC, incPC;
  logic [4:0] address;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic [4:0] branch_target = '0;
  logic       fetch_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [32];
  logic       ack_tie = 1'b0;
  int         ack_delay = 0;
  int         wait_cnt = 0;
  logic [4:0] pc_q, exec_q;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .execadd(execadd), .loadPC(loadPC), .incPC(incPC),
    .address(address), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .fetch_err(fetch_err)
  );

  // PC: command applied at the edge, execadd one register later (2-cycle latency)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      exec_q <= '0;
    end else begin
      case ({loadPC, incPC})
        2'b10:   pc_q <= address;
        2'b01:   pc_q <= pc_q + 5'd1;
        2'b00:   pc_q <= '0;
        default: pc_q <= pc_q;
      endcase
      exec_q <= pc_q;
    end
  end
  assign execadd = exec_q;

  // Memory answers after ack_delay request cycles; data is garbage except on ack
  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end
  assign mem_ack   = ack_tie | (mem_req && (wait_cnt >= ack_delay));
  assign mem_rdata = mem_ack ? mem[mem_addr] : ~mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    ack_tie = 1'b1; ir_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({loadPC, incPC, address, mem_req, mem_addr, ir, ir_valid, fetch_err} !== '0) begin
      failures++;
      $display("FAIL reset_values: got cmd=%b addr=%0d req=%b maddr=%0d ir=%h v=%b err=%b, want all 0",
               {loadPC, incPC}, address, mem_req, mem_addr, ir, ir_valid, fetch_err);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({loadPC, incPC} !== 2'b00) begin
      failures++; $display("FAIL cycle0_cmd: got %b want 00", {loadPC, incPC});
    end
    step();
    checks++;
    if ({loadPC, incPC} !== 2'b11 || mem_req !== 1'b0) begin
      failures++; $display("FAIL cycle1: cmd=%b req=%b want 11/0", {loadPC, incPC}, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL cycle2_req: got %b want 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd0 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL cycle3_fetch: req=%b maddr=%0d v=%b want 1/0/0", mem_req, mem_addr, ir_valid);
    end
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[0] || mem_req !== 1'b0) begin
      failures++; $display("FAIL cycle4_valid: v=%b ir=%h req=%b want 1/%h/0", ir_valid, ir, mem_req, mem[0]);
    end
    ack_tie = 1'b0;
  endtask

  task automatic test_stream();
    int n = 0, incs = 0, loads = 0, cyc = 0, last_v = -1, gap = -1;
    logic [7:0] exp;
    ack_delay = 0; ir_ready = 1'b1;
    do_reset();
    while (n < 33 && cyc < 400) begin
      if ({loadPC, incPC} == 2'b01) incs++;
      if ({loadPC, incPC} == 2'b10) loads++;
      if (ir_valid) begin
        exp = mem[n % 32];
        checks++;
        if (ir !== exp) begin
          failures++; $display("FAIL stream_ir[%0d]: got %h want %h", n, ir, exp);
        end
        if (n == 1) gap = cyc - last_v;
        last_v = cyc;
        n++;
      end
      if (n < 33) step();
      cyc++;
    end
    checks++;
    if (n != 33) begin
      failures++; $display("FAIL stream_timeout: got %0d instructions want 33", n);
    end
    checks++;
    if (incs != 32 || loads != 0) begin
      failures++; $display("FAIL stream_pc_cmds: incs=%0d loads=%0d want 32/0", incs, loads);
    end
    // accept edge to next valid edge is 4 clocks -> 5 sample points apart
    checks++;
    if (gap != 5) begin
      failures++; $display("FAIL stream_gap: got %0d want 5", gap);
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_ack_delay();
    int fc = 0, cyc = 0;
    logic stable = 1'b1;
    ack_delay = 5; ir_ready = 1'b0;
    do_reset();
    while (!mem_req && cyc < 20) begin step(); cyc++; end
    while (mem_req && cyc < 40) begin
      fc++;
      if (mem_addr !== 5'd0) stable = 1'b0;
      step(); cyc++;
    end
    checks++;
    if (fc != 6 || !stable) begin
      failures++; $display("FAIL ackdly_req: req cycles=%0d stable=%b want 6/1", fc, stable);
    end
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[0]) begin
      failures++; $display("FAIL ackdly_ir: v=%b ir=%h want 1/%h", ir_valid, ir, mem[0]);
    end
  endtask

  task automatic test_ir_stall();
    logic [7:0] held;
    held = ir;
    branch_taken = 1'b1; branch_target = 5'd9;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ir !== held || ir_valid !== 1'b1 || {loadPC, incPC} !== 2'b11) begin
        failures++;
        $display("FAIL stall[%0d]: ir=%h v=%b cmd=%b want %h/1/11", i, ir, ir_valid, {loadPC, incPC}, held);
      end
    end
    branch_taken = 1'b0;
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    checks++;
    if ({loadPC, incPC} !== 2'b01 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL stall_release: cmd=%b v=%b want 01/0", {loadPC, incPC}, ir_valid);
    end
  endtask

  task automatic test_branch();
    int cyc = 0, incs = 0;
    ack_delay = 0; ir_ready = 1'b1; branch_taken = 1'b0;
    do_reset();
    while (!(ir_valid && mem_addr == 5'd3) && cyc < 100) begin step(); cyc++; end
    branch_taken = 1'b1; branch_target = 5'd20;
    step();
    branch_taken = 1'b0;
    checks++;
    if ({loadPC, incPC} !== 2'b10 || address !== 5'd20) begin
      failures++; $display("FAIL branch_load: cmd=%b addr=%0d want 10/20", {loadPC, incPC}, address);
    end
    step();
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      if ({loadPC, incPC} == 2'b01 || {loadPC, incPC} == 2'b10) incs++;
      step(); cyc++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd20 || incs != 0) begin
      failures++; $display("FAIL branch_target: req=%b maddr=%0d extra_cmds=%0d want 1/20/0", mem_req, mem_addr, incs);
    end
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[20]) begin
      failures++; $display("FAIL branch_ir: v=%b ir=%h want 1/%h", ir_valid, ir, mem[20]);
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc = 0, hi = 0;
    ack_delay = 1000; ir_ready = 1'b0;
    do_reset();
    while (!mem_req && cyc < 20) begin step(); cyc++; end
`ifdef FETCH_TIMEOUT_EN
    while (mem_req && hi < 40) begin
      checks++;
      if (fetch_err !== 1'b0) begin
        failures++; $display("FAIL tmo_early_err: got %b want 0", fetch_err);
      end
      hi++; step();
    end
    checks++;
    if (hi != 15 || fetch_err !== 1'b1) begin
      failures++; $display("FAIL tmo_pulse: req cycles=%0d err=%b want 15/1", hi, fetch_err);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd0 || fetch_err !== 1'b0) begin
      failures++; $display("FAIL tmo_retry: req=%b maddr=%0d err=%b want 1/0/0", mem_req, mem_addr, fetch_err);
    end
`else
    while (hi < 20) begin
      checks++;
      if (fetch_err !== 1'b0 || mem_req !== 1'b1) begin
        failures++; $display("FAIL wait_forever[%0d]: err=%b req=%b want 0/1", hi, fetch_err, mem_req);
      end
      hi++; step();
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    int cyc = 0;
    ack_delay = 1000; ir_ready = 1'b0;
    do_reset();
    while (!mem_req && cyc < 20) begin step(); cyc++; end
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({loadPC, incPC, address, mem_req, mem_addr, ir, ir_valid, fetch_err} !== '0) begin
      failures++;
      $display("FAIL midfetch_reset: cmd=%b addr=%0d req=%b maddr=%0d ir=%h v=%b err=%b want all 0",
               {loadPC, incPC}, address, mem_req, mem_addr, ir, ir_valid, fetch_err);
    end
    ack_tie = 1'b1;
    step();
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ir_valid !== 1'b0) begin
        failures++; $display("FAIL late_ack[%0d]: v=%b want 0", i, ir_valid);
      end
      step();
    end
    checks++;
    if (ir_valid !== 1'b1 || ir !== mem[0]) begin
      failures++; $display("FAIL post_reset_fetch: v=%b ir=%h want 1/%h", ir_valid, ir, mem[0]);
    end
    ack_tie = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);
    test_reset();
    test_stream();
    test_ack_delay();
    test_ir_stall();
    test_branch();
    test_timeout();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
